// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode when nothing is valid.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Fetch FSM states.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_RUN   = RUN,
    ST_DRAIN = DRAIN
  } fetch_state_e;

  // One decode-facing queue entry at the default 32-bit widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and full/empty flags
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, decode-facing queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_WIDTH + INST_WIDTH;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   last_pc;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         drop_next;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         q_count;
  logic [CW:0]           occupancy;
  logic [EW-1:0]         q_head;
  logic                  q_empty;
  logic                  q_full;
  logic [PC_WIDTH-1:0]   pcq_head;
  logic                  pcq_empty;
  logic                  pcq_full;
  logic                  resp_take;
  logic                  resp_keep;
  logic                  req_fire;
  logic                  pop_ok;
  logic                  unused_redirect_lsbs;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The PC FIFO holds exactly the in-flight requests, so its occupancy is the
  // outstanding count and a response with nothing outstanding is ignored.
  assign resp_take = imem_resp_valid && !pcq_empty;
  assign resp_keep = resp_take && (drop_cnt == '0) && !redirect_valid && !q_full;
  assign occupancy = {1'b0, outstanding} + {1'b0, q_count};

  assign imem_req_valid = ((state == RUN) || (state == DRAIN)) && !redirect_valid
                          && (occupancy < (CW+1)'(DEPTH)) && !pcq_full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = !q_empty;
  assign pop_ok     = inst_valid && !stall && !redirect_valid;
  assign inst       = inst_valid ? q_head[INST_WIDTH-1:0] : INST_WIDTH'(NOP_INST);
  assign pc         = inst_valid ? q_head[EW-1:INST_WIDTH] : last_pc;

  // Stale-response accounting and FSM next state.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid) begin
      // Every request still in flight belongs to the old path; outstanding
      // already includes any drops left over from an earlier redirect.
      drop_next = outstanding - CW'(resp_take);
    end else if (resp_take && (drop_cnt != '0)) begin
      drop_next = drop_cnt - CW'(1);
    end

    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      default: state_next = (drop_next != '0) ? DRAIN : RUN;
    endcase
  end

  // Fetch PC, FSM, drop counter and the pc of the last instruction handed to decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      last_pc  <= RESET_PC;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      if (pop_ok) last_pc <= q_head[EW-1:INST_WIDTH];
    end
  end

  fetch_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_take),
    .head      (pcq_head),
    .count     (outstanding),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data ({pcq_head, imem_resp_data}),
    .pop       (pop_ok),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH   (32),
    .INST_WIDTH (32),
    .RESET_PC   (RPC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .pc              (pc)
  );

  int n_checks   = 0;
  int n_fails    = 0;
  int n_consumed = 0;
  int cyc        = 0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min    = 1;
  int          lat_max    = 1;
  int          ready_pct  = 100;
  int          ready_mode = 2;   // 0 random, 1 forced low, 2 forced high
  logic        ready_rand = 1'b1;

  assign imem_req_ready = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ready_rand;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ready_rand      = (int'($urandom_range(99)) < ready_pct);
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (!rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      check("outstanding_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_next;

  function automatic void model_restart(input logic [31:0] t);
    exp_q.delete();
    model_next = {t[31:2], 2'b00};
  endfunction

  function automatic void model_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endfunction

  always @(negedge clk) begin
    if (rst && !inst_valid) begin
      check("idle_nop", inst, NOP_INST);
    end
    if (rst && inst_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        timeout("scoreboard_empty");
      end else begin : cmp
        logic [31:0] e;
        e = exp_q.pop_front();
        check("consumed_pc", pc, e);
        check("consumed_inst", inst, mem_word(e));
        n_consumed++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    model_fill();
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    model_restart(t);
    model_fill();
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp_pc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) check(name, pc, exp_pc);
    else    timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        ok;
    logic [31:0] held;
    int          first_seen;

    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_restart(RPC);
    #1;
    check("reset_req_valid", imem_req_valid, 0);
    check("reset_req_addr", imem_req_addr, RPC);
    check("reset_inst_valid", inst_valid, 0);
    check("reset_inst", inst, NOP_INST);
    check("reset_pc", pc, RPC);

    // Start-up with an always-ready one-cycle memory.
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("idle_no_req", imem_req_valid, 0);
    first_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RPC);
      end
      if (inst_valid && first_seen == 0) first_seen = i;
    end
    check("first_inst_edge", first_seen, 3);
    for (int i = 0; i < 15; i++) tick();

    // Decode stall: queue fills and fetch stops issuing.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    check("stall_req_blocked", imem_req_valid, 0);
    check("stall_inst_held", inst_valid, 1);
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Redirect with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mq_addr.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("two_in_flight_reached", ok, 1);
    do_redirect(32'h0000_0100);
    wait_req("redirect_req", ok);
    if (ok) check("redirect_req_addr", imem_req_addr, 32'h0000_0100);
    wait_inst("redirect_first_pc", 32'h0000_0100);
    for (int i = 0; i < 10; i++) tick();

    // Unaligned redirect target.
    lat_min = 1;
    lat_max = 1;
    tick();
    do_redirect(32'h0000_0203);
    wait_req("unaligned_req", ok);
    if (ok) check("unaligned_req_addr", imem_req_addr, 32'h0000_0200);
    wait_inst("unaligned_first_pc", 32'h0000_0200);

    // Memory back-pressure: request address must hold.
    ready_mode = 1;
    tick();
    wait_req("ready_low_req", ok);
    held = imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("ready_low_valid", imem_req_valid, 1);
      check("ready_low_addr", imem_req_addr, held);
    end
    ready_mode = 2;
    for (int i = 0; i < 10; i++) tick();

    // PC wrap-around at the top of the address space.
    do_redirect(32'hFFFF_FFF9);
    for (int i = 0; i < 12; i++) tick();

    // Randomized traffic.
    ready_mode = 0;
    ready_pct  = 70;
    lat_min    = 1;
    lat_max    = 3;
    for (int i = 0; i < 800; i++) begin
      stall = (int'($urandom_range(99)) < 25);
      if (int'($urandom_range(99)) < 4) begin : rnd_redir
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(2))
          0:       t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
          1:       t = t & 32'h0000_0FFF;
          default: ;
        endcase
        do_redirect(t);
      end else begin
        tick();
      end
    end
    stall      = 1'b0;
    ready_mode = 2;
    for (int i = 0; i < 20; i++) tick();

    // Asynchronous reset while draining one stale request.
    lat_min    = 3;
    lat_max    = 3;
    ready_mode = 1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("pre_grant_req_valid", imem_req_valid, 1);
    ready_mode = 2;
    tick();
    ready_mode = 1;
    do_redirect(32'h0000_0040);
    #1;
    check("drain_req_addr", imem_req_addr, 32'h0000_0040);
    #2;
    rst = 1'b0;
    model_restart(RPC);
    #1;
    check("async_reset_req_valid", imem_req_valid, 0);
    check("async_reset_req_addr", imem_req_addr, RPC);
    check("async_reset_inst_valid", inst_valid, 0);
    check("async_reset_inst", inst, NOP_INST);
    check("async_reset_pc", pc, RPC);
    tick();
    tick();
    rst        = 1'b1;
    ready_mode = 2;
    lat_min    = 1;
    lat_max    = 1;
    wait_req("restart_req", ok);
    if (ok) check("restart_req_addr", imem_req_addr, RPC);
    wait_inst("restart_first_pc", RPC);
    for (int i = 0; i < 15; i++) tick();

    check("consumed_enough", 32'(n_consumed > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
